// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
// FSM states, port owners, access length codes and default timeout.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and backing-memory signals of the arbiter.
// slave = arbiter view, master = pipeline/memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [1:0]        d_len;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;

    logic              err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_len;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              stall_if;
    logic              stall_d;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_len,
        input  mem_rdata, mem_ack,
        output if_gnt, if_valid, if_rdata,
        output d_gnt, d_valid, d_rdata, err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_len,
        output stall_if, stall_d
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_len,
        output mem_rdata, mem_ack,
        input  if_gnt, if_valid, if_rdata,
        input  d_gnt, d_valid, d_rdata, err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_len,
        input  stall_if, stall_d
    );

endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between fetch and data.
// MEM_ARB_RR_EN selects round-robin; otherwise data always beats fetch.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  owner_e last_win,
    output logic   pick_if,
    output logic   pick_d
);

`ifdef MEM_ARB_RR_EN
    // On a conflict the side that did not win last time gets the port.
    always_comb begin
        pick_if = 1'b0;
        pick_d  = 1'b0;
        if (if_req && d_req) begin
            pick_d  = (last_win == OWN_IF);
            pick_if = (last_win == OWN_D);
        end else begin
            pick_d  = d_req;
            pick_if = if_req;
        end
    end
`else
    logic unused_last;
    assign unused_last = (last_win == OWN_D);

    // Fixed priority: the memory stage is older in the pipe, so it wins.
    always_comb begin
        pick_d  = d_req;
        pick_if = if_req & ~d_req;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data sides.
// Define MEM_ARB_RR_EN for round-robin arbitration (default fixed, D first).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam int            TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_q, last_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        len_q, len_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic pick_if, pick_d;
    logic idle, busy;
    logic if_gnt, d_gnt;

    mem_arb_pick u_pick (
        .if_req   (bus.if_req),
        .d_req    (bus.d_req),
        .last_win (last_q),
        .pick_if  (pick_if),
        .pick_d   (pick_d)
    );

    assign idle   = (state_q == IDLE);
    assign busy   = (state_q == BUSY);
    assign if_gnt = idle & pick_if;
    assign d_gnt  = idle & pick_d;

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.err       = err_q;
    assign bus.mem_req   = busy;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_len   = len_q;
    assign bus.stall_if  = (bus.if_req & ~if_gnt)
                         | (busy & (owner_q == OWN_IF));
    assign bus.stall_d   = (bus.d_req & ~d_gnt)
                         | (busy & (owner_q == OWN_D));

    // Next state: grant in IDLE, wait for ack or timeout in BUSY.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        timer_d    = timer_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        len_d      = len_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        err_d      = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d = BUSY;
                    owner_d = OWN_D;
                    timer_d = '0;
                    we_d    = bus.d_we;
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    len_d   = bus.d_len;
                end else if (pick_if) begin
                    state_d = BUSY;
                    owner_d = OWN_IF;
                    timer_d = '0;
                    we_d    = 1'b0;
                    addr_d  = bus.if_addr;
                    wdata_d = '0;
                    len_d   = LEN_WORD;
                end
            end
            BUSY: begin
                timer_d = timer_q + 1'b1;
                if (bus.mem_ack) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    if (owner_q == OWN_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        d_valid_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end
                end else if (timer_d == T_MAX) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    if (owner_q == OWN_IF) begin
                        if_valid_d = 1'b1;
                    end else begin
                        d_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched request fields and registered responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            last_q     <= OWN_IF;
            timer_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            len_q      <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            timer_q    <= timer_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            len_q      <= len_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the memory port arbiter.
// Directed scenarios followed by randomized fetch/data traffic.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = DEF_TIMEOUT;

    typedef struct {
        bit            is_d;
        bit            err;
        logic [DW-1:0] rdata;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    bit   glog[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    bit            if_pend, d_pend, m_busy, cur_d;
    bit            last_d_win, keep_both, rand_en;
    logic [AW-1:0] if_a, d_a, c_addr;
    logic          d_w, c_we;
    logic [DW-1:0] d_wd, c_wd, cur_data, fd, m_if_rd, m_d_rd;
    logic [1:0]    d_l, c_len;
    int            bcnt, cur_k, fk, n_left;
    logic [1:0]    lens [3] = '{LEN_BYTE, LEN_HALF, LEN_WORD};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [DW-1:0] act,
                                logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endfunction

    // Who should win, from the arbitration rules alone.
    function automatic bit win_d(bit ri, bit rd);
`ifdef MEM_ARB_RR_EN
        if (ri && rd) return !last_d_win;
`endif
        return rd;
    endfunction

    task automatic do_grant(bit is_d);
        exp_t e;
        int   r;
        cur_d = is_d;
        if (is_d) begin
            c_addr = d_a; c_we = d_w; c_wd = d_wd; c_len = d_l;
            d_pend = 0;
        end else begin
            c_addr = if_a; c_we = 0; c_wd = '0; c_len = LEN_WORD;
            if_pend = 0;
        end
        if (fk >= 0) begin
            cur_k = fk;
            cur_data = fd;
        end else begin
            r = $urandom_range(0, 5);
            cur_k = (r == 4) ? TO : (r == 5) ? 1 : r;
            cur_data = $urandom;
        end
        e.is_d = is_d;
        e.err  = (cur_k == 0);
        e.due  = cyc + ((cur_k == 0) ? TO : cur_k) + 1;
        if (cur_k != 0) begin
            last_d_win = is_d;
            if (!is_d) m_if_rd = cur_data;
            else if (!c_we) m_d_rd = cur_data;
        end
        e.rdata = is_d ? m_d_rd : m_if_rd;
        exp_q.push_back(e);
        m_busy = 1;
        bcnt = 0;
    endtask

    task automatic check_cycle();
        bit eg_d, eg_i;
        eg_d = 0;
        eg_i = 0;
        if (bus.if_gnt || bus.d_gnt) glog.push_back(bus.d_gnt);
        if (!m_busy) begin
            chk("mem_req_idle", bus.mem_req, 0);
            if (if_pend || d_pend) begin
                eg_d = win_d(if_pend, d_pend);
                eg_i = !eg_d;
            end
            chk("if_gnt", bus.if_gnt, eg_i);
            chk("d_gnt", bus.d_gnt, eg_d);
            chk("stall_if", bus.stall_if, if_pend & !eg_i);
            chk("stall_d", bus.stall_d, d_pend & !eg_d);
            if (eg_i || eg_d) do_grant(eg_d);
        end else begin
            chk("mem_req_busy", bus.mem_req, 1);
            chk("mem_addr", bus.mem_addr, c_addr);
            chk("mem_we", bus.mem_we, c_we);
            if (cur_d) begin
                chk("mem_wdata", bus.mem_wdata, c_wd);
                chk("mem_len", bus.mem_len, c_len);
            end
            chk("if_gnt_busy", bus.if_gnt, 0);
            chk("d_gnt_busy", bus.d_gnt, 0);
            chk("stall_if_busy", bus.stall_if, if_pend | !cur_d);
            chk("stall_d_busy", bus.stall_d, d_pend | cur_d);
            if (bcnt == cur_k || bcnt == TO) m_busy = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (keep_both) begin
            if_pend = 1;
            d_pend = 1;
        end
        if (rand_en && n_left > 0) begin
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1;
                if_a = AW'($urandom);
                n_left--;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1;
                d_a = AW'($urandom);
                d_w = 1'($urandom_range(0, 1));
                d_wd = $urandom;
                d_l = lens[$urandom_range(0, 2)];
                n_left--;
            end
        end
        bus.if_req = if_pend;
        bus.if_addr = if_a;
        bus.d_req = d_pend;
        bus.d_we = d_w;
        bus.d_addr = d_a;
        bus.d_wdata = d_wd;
        bus.d_len = d_l;
        if (m_busy) bcnt++;
        bus.mem_rdata = $urandom;
        bus.mem_ack = 0;
        if (m_busy && bcnt == cur_k) begin
            bus.mem_ack = 1;
            bus.mem_rdata = cur_data;
        end else if (!m_busy && $urandom_range(0, 3) == 0) begin
            bus.mem_ack = 1;
        end
        @(negedge clk);
        check_cycle();
    endtask

    task automatic drain(int lim);
        for (int i = 0; i < lim; i++) begin
            if (!if_pend && !d_pend && !m_busy && exp_q.size() == 0) break;
            step();
        end
        chk("drain_done",
            (!if_pend && !d_pend && !m_busy && exp_q.size() == 0), 1);
    endtask

    // Monitor: every completion pulse is matched against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.if_valid || bus.d_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", bus.if_valid | bus.d_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("valid_side", bus.d_valid, e.is_d);
                    chk("valid_one_hot", bus.if_valid & bus.d_valid, 0);
                    chk("valid_cycle", cyc, e.due);
                    chk("err", bus.err, e.err);
                    if (e.is_d) chk("d_rdata", bus.d_rdata, e.rdata);
                    else chk("if_rdata", bus.if_rdata, e.rdata);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                chk("missed_valid", bus.if_valid | bus.d_valid, 1);
                exp_q.delete(0);
            end
        end
    end

    initial begin
        bit exp_seq [4];
`ifdef MEM_ARB_RR_EN
        exp_seq = '{1, 0, 1, 0};
`else
        exp_seq = '{1, 1, 1, 1};
`endif
        bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
        bus.d_wdata = '0; bus.d_len = '0;
        bus.mem_rdata = '0; bus.mem_ack = 0;
        if_pend = 0; d_pend = 0; m_busy = 0; cur_d = 0;
        last_d_win = 0; keep_both = 0; rand_en = 0;
        if_a = '0; d_a = '0; d_w = 0; d_wd = '0; d_l = '0;
        c_addr = '0; c_we = 0; c_wd = '0; c_len = '0;
        cur_data = '0; fd = '0; m_if_rd = '0; m_d_rd = '0;
        bcnt = 0; cur_k = 0; fk = -1; n_left = 0;

        repeat (3) @(negedge clk);
        chk("rst_if_gnt", bus.if_gnt, 0);
        chk("rst_d_gnt", bus.d_gnt, 0);
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_d_valid", bus.d_valid, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_mem_len", bus.mem_len, 0);
        chk("rst_stall_if", bus.stall_if, 0);
        chk("rst_stall_d", bus.stall_d, 0);
        @(posedge clk);
        #1 rst_n = 1;

        // single fetch, ack in the second busy cycle
        fk = 2; fd = 32'h0050_0093;
        if_a = 12'h010; if_pend = 1;
        drain(20);
        chk("fetch_rdata_hold", bus.if_rdata, 32'h0050_0093);

        // simultaneous fetch and load
        fk = 1; fd = 32'h1234_5678;
        if_a = 12'h020; if_pend = 1;
        d_a = 12'h100; d_w = 0; d_wd = '0; d_l = LEN_WORD; d_pend = 1;
        drain(20);

        // store leaves d_rdata alone
        fk = 3; fd = 32'h5555_AAAA;
        d_a = 12'h0A4; d_w = 1; d_wd = 32'hDEAD_BEEF; d_l = LEN_WORD;
        d_pend = 1;
        drain(20);
        chk("store_keeps_d_rdata", bus.d_rdata, 32'h1234_5678);

        // load that is never acknowledged
        fk = 0; fd = 32'h7777_7777;
        d_a = 12'h0C0; d_w = 0; d_pend = 1;
        drain(40);
        chk("timeout_keeps_d_rdata", bus.d_rdata, 32'h1234_5678);

        // back-to-back conflicts: every grant sees both sides requesting
        glog.delete();
        fk = 1; fd = 32'h0F0F_0F0F;
        if_a = 12'h030; d_a = 12'h130; d_w = 0;
        keep_both = 1; if_pend = 1; d_pend = 1;
        for (int i = 0; i < 60 && glog.size() < 4; i++) step();
        keep_both = 0;
        chk("conflict_grant_count", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            chk($sformatf("conflict_grant_%0d", i), glog[i], exp_seq[i]);
        drain(40);

        // reset in the third busy cycle of a fetch
        fk = 10; fd = 32'hCAFE_0001;
        if_a = 12'h200; if_pend = 1;
        step();
        step();
        step();
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("mem_req_async_rst", bus.mem_req, 0);
        chk("rst_mid_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
        m_busy = 0; last_d_win = 0; m_if_rd = '0; m_d_rd = '0;
        if_pend = 0; d_pend = 0;
        bus.if_req = 0; bus.d_req = 0; bus.mem_ack = 0;
        @(negedge clk);
        chk("rst_mid_if_valid", bus.if_valid, 0);
        chk("rst_mid_if_rdata", bus.if_rdata, 0);
        @(posedge clk);
        #1 rst_n = 1;
        fk = 1; fd = 32'h0BAD_F00D;
        if_a = 12'h044; if_pend = 1;
        drain(20);

        // randomized traffic
        fk = -1;
        rand_en = 1;
        n_left = 300;
        for (int i = 0; i < 8000 && n_left > 0; i++) step();
        rand_en = 0;
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter sharing one backing memory port between instruction fetch (IF side) and the memory stage (D side: loads/stores). Accepts one request per idle cycle, holds the memory port until acknowledge or timeout, returns read data with a one-cycle valid pulse, and drives per-side stall signals into the pipeline hazard logic.

## Interface
- ADDR_W, 12, IF/D/memory address width in bits.
- DATA_W, 32, data width in bits.
- TIMEOUT, 15, max cycles in BUSY before abort; counter width is $clog2(TIMEOUT+1).
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  combinational one-cycle acceptance pulse.
- if_valid  out  1  registered one-cycle completion pulse.
- if_rdata  out  DATA_W  fetch data, valid with if_valid.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_len until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_len  in  2  00 byte, 01 half, 10 word; passed through unchanged.
- d_gnt  out  1  acceptance pulse.
- d_valid  out  1  completion pulse (loads and stores).
- d_rdata  out  DATA_W  load data; updated on load completions only.
- err  out  1  with a valid pulse: access timed out.
- mem_req, mem_we  out  1  memory request / write enable.
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_len  out  2.
- mem_rdata  in  DATA_W; mem_ack  in  1  one-cycle completion from memory.
- stall_if, stall_d  out  1  pipeline hold for each side.

## Operation
- States: IDLE, BUSY. Owner register: IF or D. Last-winner flag.
- IDLE: if any req, pick winner (see Configuration), assert its gnt combinationally, latch its fields into mem_* registers, set owner, clear timer, go to BUSY. The loser sees no gnt and keeps its request held.
- BUSY: mem_req=1 with latched fields stable. The timer increments each cycle.
  - On mem_ack: capture mem_rdata into the owner's rdata (IF always; D only if !mem_we), pulse the owner's valid next cycle, set last-winner=owner, go to IDLE.
  - If the timer reaches TIMEOUT without ack: drop mem_req, pulse the owner's valid with err=1, leave rdata unchanged, go to IDLE.
- mem_ack in IDLE is ignored.
- stall_x = (x_req & ~x_gnt) | (BUSY & owner==x). This is combinational, and deasserts in the cycle valid is registered.
- Reset: state IDLE, owner IF, last-winner IF, timer 0. All outputs are 0, including rdata registers.
- Reset mid-BUSY aborts the transaction with no valid pulse. mem_req falls asynchronously.

## Timing
- Request accepted in cycle 0 (IDLE, gnt=1). mem_req is high from cycle 1. Ack in cycle N≥1 gives valid/rdata in cycle N+1 with state IDLE. A new grant is possible in that same cycle N+1.
- Minimum request-to-valid latency: 2 cycles. Peak throughput: one access per 2 cycles.
- Timeout: mem_req is high for cycles 1..TIMEOUT. The valid+err pulse occurs in cycle TIMEOUT+1.
- Ack arriving in the same cycle the timer hits TIMEOUT counts as success (err=0).
- Valid, err and rdata are registered. Gnt and stall are combinational from req and state.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. On simultaneous requests the side that is not last-winner wins. The first conflict after reset goes to D.
- Undefined: fixed priority, D always beats IF. The last-winner flag is still maintained but unused.
- Single requests are granted identically in both modes.

## Structure
- mem_arb_pkg holds:
  - the state enum (IDLE, BUSY);
  - the owner enum (OWN_IF, OWN_D);
  - the length encodings (LEN_BYTE, LEN_HALF, LEN_WORD);
  - the default TIMEOUT constant.
- One sub-module, mem_arb_pick: combinational winner selection from if_req, d_req and last-winner. The RR/fixed choice is compiled inside it.

## Test plan
- Single fetch: if_req at addr 0x010, mem_ack after 2 BUSY cycles with 0x00500093. Expect if_gnt in cycle 0, if_valid with if_rdata=0x00500093 in cycle 3, err=0.
- Conflict, fixed mode: if_req and d_req (load 0x100) in the same cycle. Expect d_gnt first and stall_if held until the IF grant in the cycle of d_valid.
- Conflict, MEM_ARB_RR_EN: four back-to-back conflicting rounds. Expect grants D, IF, D, IF.
- Store: d_we=1, d_addr=0x0A4, d_wdata=0xDEADBEEF, d_len=10. Expect mem_* fields to match while busy, d_valid pulsed, and d_rdata unchanged.
- Timeout: d load with mem_ack never asserted, TIMEOUT=15. Expect mem_req high for 15 cycles, then d_valid=1 with err=1, then IDLE.
- Reset mid-BUSY: rst_n low during cycle 3 of a fetch. Expect mem_req=0 immediately, no if_valid, and a clean grant on the next request.
